// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle ARM core: streams a program into
// instruction memory with the core held in reset, then releases the core,
// counts run cycles and stops on the branch-to-self halt idiom or a timeout.
module cpu_run_controller #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 1024,
    parameter logic [31:0] HALT_INSTR = 32'hEAFFFFFE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              start,
    input  logic              abort,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    input  logic [31:0]       PC,
    input  logic [31:0]       Instr,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [31:0]       halt_pc,
    output logic [ADDR_W:0]   words_loaded,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDone,
        StError
    } state_e;

    localparam logic [ADDR_W-1:0] PtrMax     = '1;
    localparam logic [CNT_W-1:0]  CycleLimit = CNT_W'(MAX_CYCLES);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                load_ready_q, load_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [31:0]         halt_pc_q, halt_pc_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                accept;
    logic [CNT_W-1:0]    cnt_inc;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        cycle_count_d  = cycle_count_q;
        halt_pc_d      = halt_pc_q;
        words_loaded_d = words_loaded_q;
        accept         = load_valid & load_ready_q;
        cnt_inc        = cycle_count_q + 1'b1;

        if (abort) begin
            // Abort drops any same-cycle handshake; counters are held.
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (load_req) begin
                        state_d        = StLoad;
                        ptr_d          = '0;
                        words_loaded_d = '0;
                    end else if (start) begin
                        state_d       = StRun;
                        cycle_count_d = '0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        imem_we_d      = 1'b1;
                        imem_addr_d    = ptr_q;
                        imem_wdata_d   = load_data;
                        ptr_d          = ptr_q + 1'b1;
                        words_loaded_d = words_loaded_q + 1'b1;
                        if (load_last) begin
                            state_d = StIdle;
                        end else if (ptr_q == PtrMax) begin
                            // Memory full and the stream is not finished.
                            state_d = StError;
                        end
                    end
                end
                StRun: begin
                    cycle_count_d = cnt_inc;
                    if (Instr == HALT_INSTR) begin
                        state_d   = StDone;
                        halt_pc_d = PC;
                    end else if (cnt_inc == CycleLimit) begin
                        state_d = StError;
                    end
                end
                StDone: begin
                    if (start) begin
                        state_d       = StRun;
                        cycle_count_d = '0;
                    end
                end
                StError: begin
                    state_d = StError;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Status flags follow the next state so they register with it.
        load_ready_d = (state_d == StLoad);
        cpu_reset_d  = (state_d != StRun);
        busy_d       = (state_d == StLoad) || (state_d == StRun);
        done_d       = (state_d == StDone);
        error_d      = (state_d == StError);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            load_ready_q   <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_reset_q    <= 1'b1;
            cycle_count_q  <= '0;
            halt_pc_q      <= '0;
            words_loaded_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            load_ready_q   <= load_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            cycle_count_q  <= cycle_count_d;
            halt_pc_q      <= halt_pc_d;
            words_loaded_q <= words_loaded_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign load_ready   = load_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign cycle_count  = cycle_count_q;
    assign halt_pc      = halt_pc_q;
    assign words_loaded = words_loaded_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a main instance (64-word memory, 16-cycle limit)
// driven by a small core model, plus a 4-word instance for the overflow case.
module tb_cpu_run_controller;

    localparam logic [31:0] Halt = 32'hEAFFFFFE;
    localparam logic [31:0] Nop  = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0, start = 1'b0, abort = 1'b0;
    logic        load_valid = 1'b0, load_last = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready, imem_we, cpu_reset, busy, done, error;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata, halt_pc;
    logic [15:0] cycle_count;
    logic [6:0]  words_loaded;

    logic        load_req2 = 1'b0, start2 = 1'b0, abort2 = 1'b0, load_valid2 = 1'b0;
    logic        d2_load_ready, d2_imem_we, d2_cpu_reset, d2_busy, d2_done, d2_error;
    logic [1:0]  d2_imem_addr;
    logic [31:0] d2_imem_wdata, d2_halt_pc;
    logic [15:0] d2_cycle_count;
    logic [2:0]  d2_words_loaded;

    logic [31:0] pc_r = '0;
    logic [31:0] instr;
    logic [31:0] prog [64];

    int checks = 0;
    int errors = 0;

    logic [37:0] wq[$];
    logic [33:0] wq2[$];
    logic [37:0] mon_exp;
    logic [33:0] mon_exp2;

    always #5 clk = ~clk;

    // Core model: PC held at 0 in reset, otherwise advances one word per cycle.
    always @(posedge clk) pc_r <= cpu_reset ? 32'd0 : pc_r + 32'd4;
    assign instr = prog[pc_r[7:2]];

    cpu_run_controller #(.ADDR_W(6), .CNT_W(16), .MAX_CYCLES(16), .HALT_INSTR(Halt)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .start(start), .abort(abort),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .PC(pc_r), .Instr(instr),
        .cycle_count(cycle_count), .halt_pc(halt_pc), .words_loaded(words_loaded),
        .busy(busy), .done(done), .error(error)
    );

    cpu_run_controller #(.ADDR_W(2), .CNT_W(16), .MAX_CYCLES(16), .HALT_INSTR(Halt)) dut2 (
        .clk(clk), .reset(reset), .load_req(load_req2), .start(start2), .abort(abort2),
        .load_valid(load_valid2), .load_data(load_data), .load_last(load_last),
        .load_ready(d2_load_ready), .imem_we(d2_imem_we), .imem_addr(d2_imem_addr),
        .imem_wdata(d2_imem_wdata), .cpu_reset(d2_cpu_reset), .PC(pc_r), .Instr(instr),
        .cycle_count(d2_cycle_count), .halt_pc(d2_halt_pc), .words_loaded(d2_words_loaded),
        .busy(d2_busy), .done(d2_done), .error(d2_error)
    );

    // Write scoreboards: every memory write must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL imem_write: got addr=%0d data=%h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_exp = wq.pop_front();
                if ({imem_addr, imem_wdata} !== mon_exp) begin
                    errors++;
                    $display("FAIL imem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             imem_addr, imem_wdata, mon_exp[37:32], mon_exp[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (d2_imem_we === 1'b1) begin
            checks++;
            if (wq2.size() == 0) begin
                errors++;
                $display("FAIL d2_imem_write: got addr=%0d data=%h, expected no write",
                         d2_imem_addr, d2_imem_wdata);
            end else begin
                mon_exp2 = wq2.pop_front();
                if ({d2_imem_addr, d2_imem_wdata} !== mon_exp2) begin
                    errors++;
                    $display("FAIL d2_imem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             d2_imem_addr, d2_imem_wdata, mon_exp2[33:32], mon_exp2[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until done/error or the bound; returns cycles with the core released.
    task automatic run_until_stop(output int low);
        int k = 0;
        low = 0;
        while (!(done === 1'b1 || error === 1'b1) && k < 100) begin
            if (cpu_reset === 1'b0) low++;
            tick();
            k++;
        end
        checks++;
        if (k == 100) begin
            errors++;
            $display("FAIL run_bound: no done/error within 100 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({load_ready, imem_we, busy, done, error, cpu_reset} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000001",
                     {load_ready, imem_we, busy, done, error, cpu_reset});
        end
        checks++;
        if ({imem_addr, imem_wdata, cycle_count, halt_pc, words_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_values: addr=%0d wdata=%h cnt=%0d hpc=%h wl=%0d, expected all 0",
                     imem_addr, imem_wdata, cycle_count, halt_pc, words_loaded);
        end
    endtask

    task automatic test_load();
        logic [31:0] w [3];
        w[0] = 32'hE3A00005;
        w[1] = 32'hE3A01007;
        w[2] = Halt;
        for (int i = 0; i < 64; i++) prog[i] = Nop;
        for (int i = 0; i < 3; i++) prog[i] = w[i];
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        checks++;
        if ({load_ready, busy, cpu_reset} !== 3'b111) begin
            errors++;
            $display("FAIL load_entry: ready/busy/cpu_reset=%b, expected 111",
                     {load_ready, busy, cpu_reset});
        end
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = w[i];
            load_last  = (i == 2);
            wq.push_back({6'(i), w[i]});
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++;
        if ({load_ready, busy, cpu_reset, words_loaded} !== {3'b001, 7'd3}) begin
            errors++;
            $display("FAIL load_exit: ready/busy/cpu_reset=%b wl=%0d, expected 001 wl=3",
                     {load_ready, busy, cpu_reset}, words_loaded);
        end
        tick();
        checks++;
        if (wq.size() != 0 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL load_writes: %0d writes missing, we=%b, expected 0 and 0",
                     wq.size(), imem_we);
        end
    endtask

    task automatic test_run_halt();
        int low;
        for (int rep = 0; rep < 2; rep++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            run_until_stop(low);
            checks++;
            if (low != 3 || cycle_count !== 16'd3 || halt_pc !== 32'd8) begin
                errors++;
                $display("FAIL run_halt[%0d]: low=%0d cnt=%0d hpc=%0d, expected 3 3 8",
                         rep, low, cycle_count, halt_pc);
            end
            checks++;
            if ({done, error, busy, cpu_reset} !== 4'b1001) begin
                errors++;
                $display("FAIL halt_flags[%0d]: done/err/busy/cpu_reset=%b, expected 1001",
                         rep, {done, error, busy, cpu_reset});
            end
            if (rep == 0) begin
                load_req = 1'b1;
                tick();
                load_req = 1'b0;
                checks++;
                if ({done, load_ready, busy} !== 3'b100) begin
                    errors++;
                    $display("FAIL done_ignores_load: done/ready/busy=%b, expected 100",
                             {done, load_ready, busy});
                end
            end
        end
    endtask

    task automatic test_timeout();
        int low;
        for (int i = 0; i < 64; i++) prog[i] = Nop;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_stop(low);
        checks++;
        if (low != 16 || cycle_count !== 16'd16 || {error, done, cpu_reset} !== 3'b101) begin
            errors++;
            $display("FAIL timeout: low=%0d cnt=%0d err/done/cpu_reset=%b, expected 16 16 101",
                     low, cycle_count, {error, done, cpu_reset});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL error_sticky: error=%b busy=%b, expected 1 0", error, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (error !== 1'b0 || cycle_count !== 16'd16) begin
            errors++;
            $display("FAIL error_abort: error=%b cnt=%0d, expected 0 16", error, cycle_count);
        end
        prog[15] = Halt;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_stop(low);
        checks++;
        if ({done, error} !== 2'b10 || cycle_count !== 16'd16 || halt_pc !== 32'd60) begin
            errors++;
            $display("FAIL halt_at_limit: done/err=%b cnt=%0d hpc=%0d, expected 10 16 60",
                     {done, error}, cycle_count, halt_pc);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        load_req2 = 1'b1;
        tick();
        load_req2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 32'hA0000000 + 32'(i);
            load_valid2 = 1'b1;
            load_data   = d;
            load_last   = 1'b0;
            if (i < 4) wq2.push_back({2'(i), d});
            tick();
            if (i == 3) begin
                checks++;
                if ({d2_error, d2_load_ready, d2_busy} !== 3'b100 || d2_words_loaded !== 3'd4) begin
                    errors++;
                    $display("FAIL overflow: err/ready/busy=%b wl=%0d, expected 100 wl=4",
                             {d2_error, d2_load_ready, d2_busy}, d2_words_loaded);
                end
            end
        end
        load_valid2 = 1'b0;
        tick();
        checks++;
        if (wq2.size() != 0) begin
            errors++;
            $display("FAIL overflow_writes: %0d writes missing, expected 0", wq2.size());
        end
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        checks++;
        if ({d2_error, d2_busy, d2_cpu_reset} !== 3'b001) begin
            errors++;
            $display("FAIL overflow_abort: err/busy/cpu_reset=%b, expected 001",
                     {d2_error, d2_busy, d2_cpu_reset});
        end
    endtask

    task automatic test_abort_backpressure();
        logic [4:0] v  = 5'b10101;
        logic [4:0] ab = 5'b10000;
        logic [5:0] ptr = '0;
        logic [31:0] d;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d          = $urandom;
            load_valid = v[i];
            abort      = ab[i];
            load_data  = d;
            load_last  = 1'b0;
            if (v[i] && !ab[i]) begin
                wq.push_back({ptr, d});
                ptr++;
            end
            tick();
        end
        load_valid = 1'b0;
        abort      = 1'b0;
        checks++;
        if ({busy, load_ready, imem_we} !== 3'b000 || words_loaded !== 7'd2) begin
            errors++;
            $display("FAIL abort_load: busy/ready/we=%b wl=%0d, expected 000 wl=2",
                     {busy, load_ready, imem_we}, words_loaded);
        end
        tick();
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL abort_writes: %0d writes missing, expected 0", wq.size());
        end
        load_req = 1'b1;
        start    = 1'b1;
        tick();
        load_req = 1'b0;
        start    = 1'b0;
        checks++;
        if ({busy, load_ready, cpu_reset} !== 3'b111 || words_loaded !== 7'd0) begin
            errors++;
            $display("FAIL load_wins: busy/ready/cpu_reset=%b wl=%0d, expected 111 wl=0",
                     {busy, load_ready, cpu_reset}, words_loaded);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_sync_reset();
        for (int i = 0; i < 64; i++) prog[i] = Nop;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, cpu_reset} !== 2'b10 || cycle_count !== 16'd2) begin
            errors++;
            $display("FAIL reset_no_edge: busy/cpu_reset=%b cnt=%0d, expected 10 cnt=2",
                     {busy, cpu_reset}, cycle_count);
        end
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, error, cpu_reset} !== 4'b0001 || cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_run: busy/done/err/cpu_reset=%b cnt=%0d, expected 0001 0",
                     {busy, done, error, cpu_reset}, cycle_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = Nop;
        test_reset();
        test_load();
        test_run_halt();
        test_timeout();
        test_overflow();
        test_abort_backpressure();
        test_sync_reset();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
